individual_fitness_scorer: RTL

- Sequential scoring engine on the consuming side of evolved candidate blocks: four 16-bit outputs (y3..y0) per test vector.
- Each beat carries the candidate outputs and the golden outputs for one vector.
- Accumulates bit mismatches and exact-vector matches over a fixed-length run, then reports a fitness result with a one-cycle done pulse.
- Sits between the vector driver and the GE fitness collector in the evaluation harness.

---
 rtl/individual_eval_pkg.sv | 19 +
 rtl/popcount64.sv | 19 +
 rtl/individual_fitness_scorer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/individual_eval_pkg.sv
// Shared definitions for the individual fitness scorer.
//   W_DEF / NVEC_DEF     : default output-word width and vectors per run
//   ERR_W_DEF / CNT_W_DEF: accumulator widths matching the defaults
//   fsm_state_e          : scorer control states
package individual_eval_pkg;

    localparam int unsigned W_DEF     = 16;
    localparam int unsigned NVEC_DEF  = 256;
    localparam int unsigned ERR_W_DEF = $clog2(NVEC_DEF * 4 * W_DEF + 1);
    localparam int unsigned CNT_W_DEF = $clog2(NVEC_DEF + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StReport
    } fsm_state_e;

endpackage

// File: rtl/popcount64.sv
// Combinational population count.
//   vec_i : Width-bit input vector
//   cnt_o : number of set bits in vec_i
module popcount64 #(
    parameter int unsigned Width = 64,
    parameter int unsigned CntW  = $clog2(Width + 1)
) (
    input  logic [Width-1:0] vec_i,
    output logic [CntW-1:0]  cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < Width; i++) begin
            cnt_o = cnt_o + CntW'(vec_i[i]);
        end
    end

endmodule

// File: rtl/individual_fitness_scorer.sv
// Fitness scorer for evolved candidate blocks with four W-bit outputs.
// Each accepted beat is compared against golden outputs through a two-stage
// pipeline (XOR, then popcount/zero flag); mismatching bits and exact-match
// vectors are accumulated over NVEC beats, then a one-cycle done pulse
// presents the final result.
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a run (honoured in IDLE and REPORT only)
//   busy                : run in progress (RUN or DRAIN)
//   in_valid / in_ready : beat handshake
//   cand_y* / ref_y*    : candidate and golden output words
//   done                : one-cycle pulse when results are final
//   bit_err, vec_match  : mismatching bit total, fully-matching vector total
//   perfect             : bit_err == 0, latched on entry to REPORT
module individual_fitness_scorer
    import individual_eval_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned NVEC  = NVEC_DEF,
    parameter int unsigned ERR_W = $clog2(NVEC * 4 * W + 1),
    parameter int unsigned CNT_W = $clog2(NVEC + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     cand_y3,
    input  logic [W-1:0]     cand_y2,
    input  logic [W-1:0]     cand_y1,
    input  logic [W-1:0]     cand_y0,
    input  logic [W-1:0]     ref_y3,
    input  logic [W-1:0]     ref_y2,
    input  logic [W-1:0]     ref_y1,
    input  logic [W-1:0]     ref_y0,
    output logic             done,
    output logic [ERR_W-1:0] bit_err,
    output logic [CNT_W-1:0] vec_match,
    output logic             perfect
);

    localparam int unsigned VecW = 4 * W;
    localparam int unsigned PopW = $clog2(VecW + 1);

    fsm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] bit_err_q, bit_err_d;
    logic [CNT_W-1:0] vec_match_q, vec_match_d;
    logic             perfect_q, perfect_d;
    logic             done_q, done_d;

    logic             s1_valid_q, s1_valid_d;
    logic [VecW-1:0]  s1_xor_q, s1_xor_d;
    logic             s2_valid_q, s2_valid_d;
    logic [PopW-1:0]  s2_pop_q, s2_pop_d;
    logic             s2_zero_q, s2_zero_d;

    logic [PopW-1:0]  s1_pop;
    logic             accept;

    popcount64 #(
        .Width (VecW),
        .CntW  (PopW)
    ) u_popcount (
        .vec_i (s1_xor_q),
        .cnt_o (s1_pop)
    );

    // The last acceptance moves the FSM to DRAIN, so RUN alone implies room.
    assign in_ready = (state_q == StRun);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_err_d   = bit_err_q;
        vec_match_d = vec_match_q;
        perfect_d   = perfect_q;
        done_d      = 1'b0;

        // Payload registers only load on a real transfer / valid stage.
        s1_valid_d = accept;
        s1_xor_d   = s1_xor_q;
        if (accept) begin
            s1_xor_d = {cand_y3 ^ ref_y3, cand_y2 ^ ref_y2,
                        cand_y1 ^ ref_y1, cand_y0 ^ ref_y0};
        end

        s2_valid_d = s1_valid_q;
        s2_pop_d   = s2_pop_q;
        s2_zero_d  = s2_zero_q;
        if (s1_valid_q) begin
            s2_pop_d  = s1_pop;
            s2_zero_d = (s1_xor_q == '0);
        end

        if (s2_valid_q) begin
            bit_err_d   = bit_err_q + ERR_W'(s2_pop_q);
            vec_match_d = vec_match_q + CNT_W'(s2_zero_q);
        end

        unique case (state_q)
            StIdle, StReport: begin
                if (start) begin
                    state_d     = StRun;
                    cnt_d       = '0;
                    bit_err_d   = '0;
                    vec_match_d = '0;
                    perfect_d   = 1'b0;
                end else if (state_q == StReport) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(NVEC - 1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // With S1 empty, the beat in S2 (if any) lands on this edge,
                // so bit_err_d is already the final total.
                if (!s1_valid_q) begin
                    state_d   = StReport;
                    done_d    = 1'b1;
                    perfect_d = (bit_err_d == '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_err_q   <= '0;
            vec_match_q <= '0;
            perfect_q   <= 1'b0;
            done_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_xor_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_pop_q    <= '0;
            s2_zero_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_err_q   <= bit_err_d;
            vec_match_q <= vec_match_d;
            perfect_q   <= perfect_d;
            done_q      <= done_d;
            s1_valid_q  <= s1_valid_d;
            s1_xor_q    <= s1_xor_d;
            s2_valid_q  <= s2_valid_d;
            s2_pop_q    <= s2_pop_d;
            s2_zero_q   <= s2_zero_d;
        end
    end

    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign done      = done_q;
    assign bit_err   = bit_err_q;
    assign vec_match = vec_match_q;
    assign perfect   = perfect_q;

endmodule
